// File: rtl/delay_spram_sequencer.sv
// Drives a single-port synchronous-read SPRAM as the chorus circular delay line.
// Each sample takes four cycles: write slot, read slot, capture, then return to idle.
module delay_spram_sequencer #(
  parameter int BUF_DEPTH  = 7680,
  parameter int PKT_WIDTH  = 16,
  parameter int ADDR_WIDTH = $clog2(BUF_DEPTH),
  parameter int AVG_DELAY  = 882,
  parameter int MAX_DELAY  = BUF_DEPTH - 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PKT_WIDTH-1:0]  pkt_i,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [ADDR_WIDTH-1:0] extra_read_addr_delay_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [PKT_WIDTH-1:0]  ram_wdata_o,
  output logic                  ram_we_o,
  input  logic [PKT_WIDTH-1:0]  ram_rdata_i,
  output logic [PKT_WIDTH-1:0]  pkt_delayed_o,
  output logic                  pkt_delayed_valid_o
);

  if (AVG_DELAY >= BUF_DEPTH - 10) begin : g_bad_delay
    $fatal(1, "delay_spram_sequencer: AVG_DELAY must be below BUF_DEPTH-10");
  end

  localparam logic [ADDR_WIDTH:0]   AVG_W     = (ADDR_WIDTH+1)'(AVG_DELAY);
  localparam logic [ADDR_WIDTH:0]   MAX_W     = (ADDR_WIDTH+1)'(MAX_DELAY);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MAX_A     = ADDR_WIDTH'(MAX_DELAY);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] total_delay;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH:0]   fill_cnt;
  logic [ADDR_WIDTH:0]   sum;
  logic [PKT_WIDTH-1:0]  sample_reg;
  logic                  mute;

  // One extra bit so AVG_DELAY + extra can never overflow before the clamp.
  assign sum = AVG_W + {1'b0, extra_read_addr_delay_i};

  // Modular subtraction in ADDR_WIDTH bits is exact because the true result
  // always lies in [0, BUF_DEPTH).
  assign read_addr = (write_addr >= total_delay) ? (write_addr - total_delay)
                                                 : (write_addr + DEPTH_A - total_delay);

  assign ram_we_o    = (state == WRITE);
  assign ram_addr_o  = (state == READ) ? read_addr : write_addr;
  assign ram_wdata_o = sample_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      write_addr          <= '0;
      fill_cnt            <= '0;
      total_delay         <= '0;
      sample_reg          <= '0;
      mute                <= 1'b1;
      pkt_ready_o         <= 1'b1;
      pkt_delayed_o       <= '0;
      pkt_delayed_valid_o <= 1'b0;
    end else begin
      pkt_delayed_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_valid_i) begin
            sample_reg  <= pkt_i;
            total_delay <= (sum > MAX_W) ? MAX_A : sum[ADDR_WIDTH-1:0];
            pkt_ready_o <= 1'b0;
            state       <= WRITE;
          end
        end
        WRITE: state <= READ;
        READ: begin
          // Fill level before this sample counts; saturation keeps mute off for good.
          mute       <= (fill_cnt < {1'b0, total_delay});
          write_addr <= (write_addr == LAST_ADDR) ? '0 : write_addr + 1'b1;
          if (fill_cnt != DEPTH_W) fill_cnt <= fill_cnt + 1'b1;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          pkt_delayed_o       <= mute ? '0 : ram_rdata_i;
          pkt_delayed_valid_o <= 1'b1;
          pkt_ready_o         <= 1'b1;
          state               <= IDLE;
        end
        default: begin
          state       <= IDLE;
          pkt_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_spram_sequencer.sv
// Scoreboard bench for delay_spram_sequencer with a behavioural SPRAM (BUF_DEPTH=16, AVG_DELAY=4).
module tb_delay_spram_sequencer;
  localparam int BD = 16, PW = 16, AW = 4, AVG = 4, MAXD = BD - 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pkt_i = '0;
  logic          pkt_valid_i = 1'b0;
  logic          pkt_ready_o;
  logic [AW-1:0] extra = '0;
  logic [AW-1:0] ram_addr;
  logic [PW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;
  logic [PW-1:0] pkt_delayed;
  logic          pkt_delayed_valid;

  delay_spram_sequencer #(.BUF_DEPTH(BD), .PKT_WIDTH(PW), .ADDR_WIDTH(AW), .AVG_DELAY(AVG), .MAX_DELAY(MAXD)) dut (
    .clk(clk), .rst(rst), .pkt_i(pkt_i), .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .extra_read_addr_delay_i(extra), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_we_o(ram_we), .ram_rdata_i(ram_rdata), .pkt_delayed_o(pkt_delayed),
    .pkt_delayed_valid_o(pkt_delayed_valid));

  always #5 clk = ~clk;

  logic [PW-1:0] mem [BD];
  initial for (int i = 0; i < BD; i++) mem[i] = 16'hdead;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int errors = 0, checks = 0, cyc = 0, n_acc = 0, writes = 0, last_xfer = 0, gap = 0;
  int hist [256];
  logic [PW-1:0] exp_q[$];
  int            exp_t[$];
  int            wq_addr[$];
  logic [PW-1:0] wq_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        writes++;
        checks++;
        if (pkt_ready_o !== 1'b0) begin
          errors++; $display("FAIL we_while_ready: ready=%b required 0", pkt_ready_o);
        end
        checks++;
        if (wq_addr.size() == 0) begin
          errors++; $display("FAIL unexpected_write: addr=%0d data=%0d", ram_addr, ram_wdata);
        end else begin
          int ea; logic [PW-1:0] ed;
          ea = wq_addr.pop_front(); ed = wq_data.pop_front();
          if (ram_addr !== AW'(ea) || ram_wdata !== ed) begin
            errors++;
            $display("FAIL ram_write: addr=%0d data=%0d required addr=%0d data=%0d", ram_addr, ram_wdata, ea, ed);
          end
        end
      end
      if (pkt_delayed_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_strobe: data=%0d", pkt_delayed);
        end else begin
          logic [PW-1:0] e; int t;
          e = exp_q.pop_front(); t = exp_t.pop_front();
          if (pkt_delayed !== e) begin
            errors++; $display("FAIL delayed_data: got %0d required %0d", pkt_delayed, e);
          end
          checks++;
          // Strobe is launched by the third edge after the transfer edge (fourth cycle).
          if (cyc - t != 3) begin
            errors++; $display("FAIL latency: got %0d edges required 3", cyc - t);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    pkt_valid_i = 1'b0;
    exp_q.delete(); exp_t.delete(); wq_addr.delete(); wq_data.delete();
    n_acc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one sample, waits for acceptance and records the model's expectations.
  task automatic send(input logic [PW-1:0] s, input logic [AW-1:0] ex);
    int b = 0, d, fill;
    @(negedge clk);
    while (pkt_ready_o !== 1'b1 && b < 16) begin @(negedge clk); b++; end
    if (b >= 16) begin
      checks++; errors++; $display("FAIL send_timeout: ready=%b required 1", pkt_ready_o);
      return;
    end
    pkt_i = s; extra = ex; pkt_valid_i = 1'b1;
    @(posedge clk); #1;
    gap = cyc - last_xfer; last_xfer = cyc;
    d    = (AVG + int'(ex) > MAXD) ? MAXD : AVG + int'(ex);
    fill = (n_acc < BD) ? n_acc : BD;
    exp_q.push_back((fill < d) ? PW'(0) : PW'(hist[n_acc - d]));
    exp_t.push_back(cyc);
    wq_addr.push_back(n_acc % BD);
    wq_data.push_back(s);
    hist[n_acc] = int'(s);
    n_acc++;
  endtask

  task automatic stop();
    pkt_valid_i = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 40) begin @(negedge clk); #1; b++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_timeout: %0d outputs pending required 0", exp_q.size());
      exp_q.delete(); exp_t.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", pkt_ready_o); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b required 0", ram_we); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d required 0", ram_addr); end
    checks++; if (pkt_delayed !== '0) begin errors++; $display("FAIL rst_out: got %0d required 0", pkt_delayed); end
    checks++; if (pkt_delayed_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", pkt_delayed_valid); end
  endtask

  task automatic test_fill_mute();
    int w0 = writes;
    for (int i = 1; i <= 8; i++) send(PW'(i), '0);
    stop();
    drain();
    checks++; if (writes - w0 != 8) begin errors++; $display("FAIL fill_writes: got %0d required 8", writes - w0); end
    checks++; if (pkt_delayed !== 16'd4) begin errors++; $display("FAIL fill_last: got %0d required 4", pkt_delayed); end
  endtask

  task automatic test_back_to_back();
    int w0 = writes;
    for (int i = 0; i < 40; i++) begin
      send(PW'(200 + i), '0);
      if (i > 0) begin
        checks++;
        if (gap != 4) begin errors++; $display("FAIL b2b_gap: got %0d cycles required 4", gap); end
      end
    end
    stop();
    drain();
    checks++; if (writes - w0 != 40) begin errors++; $display("FAIL b2b_writes: got %0d required 40", writes - w0); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 21; i++) send(PW'(i), '0);
    stop();
    drain();
    // Sample 21 is written at address 4 and reads address 0, which holds sample 17.
    checks++; if (pkt_delayed !== 16'd17) begin errors++; $display("FAIL wrap: got %0d required 17", pkt_delayed); end
  endtask

  task automatic test_clamp();
    for (int i = 100; i <= 107; i++) send(PW'(i), 4'd15);
    stop();
    drain();
    checks++; if (pkt_delayed !== 16'd101) begin errors++; $display("FAIL clamp15: got %0d required 101", pkt_delayed); end
    for (int i = 108; i <= 110; i++) send(PW'(i), 4'd2);
    stop();
    drain();
    checks++; if (pkt_delayed !== 16'd104) begin errors++; $display("FAIL clamp2: got %0d required 104", pkt_delayed); end
  endtask

  task automatic test_lfo_midflight();
    send(16'd50, '0);
    stop();
    extra = 4'd2;
    drain();
    checks++; if (pkt_delayed !== 16'd107) begin errors++; $display("FAIL lfo_inflight: got %0d required 107", pkt_delayed); end
    send(16'd51, 4'd2);
    stop();
    drain();
    checks++; if (pkt_delayed !== 16'd106) begin errors++; $display("FAIL lfo_next: got %0d required 106", pkt_delayed); end
  endtask

  task automatic test_reset_midseq();
    send(16'd77, '0);
    stop();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); exp_t.delete(); wq_addr.delete(); wq_data.delete();
    n_acc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", pkt_ready_o); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL midrst_addr: got %0d required 0", ram_addr); end
    checks++; if (pkt_delayed !== '0) begin errors++; $display("FAIL midrst_out: got %0d required 0", pkt_delayed); end
    checks++; if (pkt_delayed_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", pkt_delayed_valid); end
    repeat (6) @(negedge clk);
    send(16'd5, '0);
    stop();
    drain();
    checks++; if (pkt_delayed !== '0) begin errors++; $display("FAIL midrst_mute: got %0d required 0", pkt_delayed); end
  endtask

  initial begin
    test_reset();
    test_fill_mute();
    test_back_to_back();
    test_wrap();
    test_clamp();
    test_lfo_midflight();
    test_reset_midseq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
